// File: rtl/stdp_controller.sv
// STDP learning-rule sequencer: measures pre/post spike timing with saturating age counters and
// applies one clamped potentiation/depression step per event via an evaluate/apply FSM.
module stdp_controller #(
    parameter int unsigned W_WIDTH  = 6,
    parameter int unsigned W_INIT   = 32,
    parameter int unsigned W_MAX    = 63,
    parameter int unsigned W_MIN    = 0,
    parameter int unsigned WINDOW   = 15,
    parameter int unsigned LTP_STEP = 2,
    parameter int unsigned LTD_STEP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               learn_en,
    input  logic               pre_spike,
    input  logic               post_spike,
    input  logic               cfg_load,
    input  logic [W_WIDTH-1:0] cfg_weight,
    output logic [W_WIDTH-1:0] weight_out,
    output logic               update_valid,
    output logic               update_ltp,
    output logic               update_sat,
    output logic               busy,
    output logic               overrun
);

    localparam int unsigned CW  = $clog2(WINDOW + 2);
    localparam int unsigned WW1 = W_WIDTH + 1;
    localparam logic [CW-1:0]  AgeMax = CW'(WINDOW + 1);
    localparam logic [CW-1:0]  Win    = CW'(WINDOW);
    localparam logic [CW-1:0]  Half   = CW'(WINDOW >> 1);
    localparam logic [WW1-1:0] WMax   = WW1'(W_MAX);
    localparam logic [WW1-1:0] WMin   = WW1'(W_MIN);

    typedef enum logic [1:0] {StIdle, StEval, StApply} state_e;

    state_e state_q, state_d;

    logic [CW-1:0]      t_pre_q, t_post_q;
    logic               ev_valid, ev_ltp;
    logic [CW-1:0]      ev_dt;
    logic               cur_ltp_q;
    logic [CW-1:0]      cur_dt_q;
    logic               q_valid_q, q_valid_d, q_ltp_q;
    logic [CW-1:0]      q_dt_q;
    logic               drain, load_cur_ev, ev_enq, ev_drop, busy_d;
    logic [W_WIDTH-1:0] weight_q, next_w_q, eval_w, cfg_w;
    logic               next_sat_q, eval_sat, cfg_lo;
    logic [WW1-1:0]     step, w_ext, sum, cfg_ext;
    logic               valid_q, ltp_q, sat_q, busy_q, overrun_q;

    // Age counters: time since the last spike, saturating at WINDOW+1 (no history).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_pre_q  <= AgeMax;
            t_post_q <= AgeMax;
        end else if (en) begin
            if (pre_spike)             t_pre_q <= CW'(1);
            else if (t_pre_q != AgeMax) t_pre_q <= t_pre_q + 1'b1;
            if (post_spike)              t_post_q <= CW'(1);
            else if (t_post_q != AgeMax) t_post_q <= t_post_q + 1'b1;
        end
    end

    always_comb begin
        ev_valid = 1'b0;
        ev_ltp   = 1'b0;
        ev_dt    = t_pre_q;
        if (en && learn_en && !cfg_load) begin
            if (post_spike && !pre_spike && t_pre_q <= Win) begin
                ev_valid = 1'b1;
                ev_ltp   = 1'b1;
                ev_dt    = t_pre_q;
            end else if (pre_spike && !post_spike && t_post_q <= Win) begin
                ev_valid = 1'b1;
                ev_ltp   = 1'b0;
                ev_dt    = t_post_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (ev_valid || q_valid_q) state_d = StEval;
                StEval:  state_d = StApply;
                StApply: state_d = q_valid_q ? StEval : StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Queue steering: an idle FSM with an empty queue takes the event directly.
    always_comb begin
        drain       = q_valid_q && (state_q == StIdle || state_q == StApply);
        load_cur_ev = ev_valid && state_q == StIdle && !q_valid_q;
        ev_enq      = ev_valid && !load_cur_ev && (!q_valid_q || drain);
        ev_drop     = ev_valid && !load_cur_ev && !ev_enq;
        if (cfg_load)    q_valid_d = 1'b0;
        else if (ev_enq) q_valid_d = 1'b1;
        else if (drain)  q_valid_d = 1'b0;
        else             q_valid_d = q_valid_q;
        busy_d = !cfg_load && ((state_d != StIdle) || q_valid_d);
    end

    always_comb begin
        if (cur_dt_q <= Half) step = cur_ltp_q ? WW1'(LTP_STEP) : WW1'(LTD_STEP);
        else                  step = WW1'(1);
        w_ext    = {1'b0, weight_q};
        sum      = '0;
        eval_sat = 1'b0;
        if (cur_ltp_q) begin
            sum = w_ext + step;
            if (sum > WMax) begin
                eval_w   = W_WIDTH'(W_MAX);
                eval_sat = 1'b1;
            end else begin
                eval_w = sum[W_WIDTH-1:0];
            end
        end else begin
            sum = w_ext - step;
            if (w_ext < WMin + step) begin
                eval_w   = W_WIDTH'(W_MIN);
                eval_sat = 1'b1;
            end else begin
                eval_w = sum[W_WIDTH-1:0];
            end
        end
    end

    assign cfg_ext = {1'b0, cfg_weight};
    if (W_MIN > 0) begin : g_cfg_lo
        assign cfg_lo = cfg_ext < WMin;
    end else begin : g_cfg_nolo
        assign cfg_lo = 1'b0;
    end

    always_comb begin
        if (cfg_ext > WMax) cfg_w = W_WIDTH'(W_MAX);
        else if (cfg_lo)    cfg_w = W_WIDTH'(W_MIN);
        else                cfg_w = cfg_weight;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_q   <= W_WIDTH'(W_INIT);
            next_w_q   <= '0;
            next_sat_q <= 1'b0;
            cur_ltp_q  <= 1'b0;
            cur_dt_q   <= '0;
            q_ltp_q    <= 1'b0;
            q_dt_q     <= '0;
            q_valid_q  <= 1'b0;
            valid_q    <= 1'b0;
            ltp_q      <= 1'b0;
            sat_q      <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            q_valid_q <= q_valid_d;
            busy_q    <= busy_d;
            if (cfg_load) begin
                weight_q  <= cfg_w;
                overrun_q <= 1'b0;
            end else begin
                if (state_q == StEval) begin
                    next_w_q   <= eval_w;
                    next_sat_q <= eval_sat;
                end
                if (state_q == StApply) begin
                    weight_q <= next_w_q;
                    valid_q  <= 1'b1;
                    ltp_q    <= cur_ltp_q;
                    sat_q    <= next_sat_q;
                end
                if (ev_drop) overrun_q <= 1'b1;
                if (load_cur_ev) begin
                    cur_ltp_q <= ev_ltp;
                    cur_dt_q  <= ev_dt;
                end else if (drain) begin
                    cur_ltp_q <= q_ltp_q;
                    cur_dt_q  <= q_dt_q;
                end
                if (ev_enq) begin
                    q_ltp_q <= ev_ltp;
                    q_dt_q  <= ev_dt;
                end
            end
        end
    end

    assign weight_out   = weight_q;
    assign update_valid = valid_q;
    assign update_ltp   = ltp_q;
    assign update_sat   = sat_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_stdp_controller.sv
// Self-checking bench for stdp_controller: timestamp/deadline reference model, directed scenarios
// with literal expectations, then randomized spike traffic compared every cycle.
module tb_stdp_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, learn_en = 1'b0, pre_spike = 1'b0, post_spike = 1'b0, cfg_load = 1'b0;
    logic [5:0] cfg_weight = '0;
    logic [5:0] weight_out;
    logic       update_valid, update_ltp, update_sat, busy, overrun;

    stdp_controller dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .learn_en     (learn_en),
        .pre_spike    (pre_spike),
        .post_spike   (post_spike),
        .cfg_load     (cfg_load),
        .cfg_weight   (cfg_weight),
        .weight_out   (weight_out),
        .update_valid (update_valid),
        .update_ltp   (update_ltp),
        .update_sat   (update_sat),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    bit chk_on   = 1'b0;

    // Reference model: spike timestamps in enabled-edge time, plus an in-flight update with a
    // completion deadline and a one-deep pending slot.
    int now, etime, last_pre, last_post;
    int m_w, m_valid, m_ltp, m_sat, m_ovr;
    int inf_v, inf_ltp, inf_dt, inf_due;
    int pend_v, pend_ltp, pend_dt;

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        now = 0; etime = 0; last_pre = -1000; last_post = -1000;
        m_w = 32; m_valid = 0; m_ltp = 0; m_sat = 0; m_ovr = 0;
        inf_v = 0; inf_ltp = 0; inf_dt = 0; inf_due = 0;
        pend_v = 0; pend_ltp = 0; pend_dt = 0;
    endtask

    task automatic model_step(input int p, input int q, input int l, input int e, input int c,
                              input int w);
        int fsm_active, had_pend, ev, ev_ltp, ev_dt, step, r;
        now++;
        fsm_active = inf_v;
        had_pend   = pend_v;
        ev = 0; ev_ltp = 0; ev_dt = 0;
        if (e != 0) begin
            etime++;
            if (l != 0 && c == 0 && q != 0 && p == 0 && etime - last_pre <= 15) begin
                ev = 1; ev_ltp = 1; ev_dt = etime - last_pre;
            end else if (l != 0 && c == 0 && p != 0 && q == 0 && etime - last_post <= 15) begin
                ev = 1; ev_ltp = 0; ev_dt = etime - last_post;
            end
            if (p != 0) last_pre = etime;
            if (q != 0) last_post = etime;
        end
        m_valid = 0;
        if (c != 0) begin
            m_w = (w > 63) ? 63 : w;
            inf_v = 0; pend_v = 0; m_ovr = 0;
        end else begin
            if (inf_v != 0 && inf_due == now) begin
                step = (inf_dt <= 7) ? ((inf_ltp != 0) ? 2 : 1) : 1;
                r = (inf_ltp != 0) ? m_w + step : m_w - step;
                m_sat = 0;
                if (r > 63) begin r = 63; m_sat = 1; end
                if (r < 0)  begin r = 0;  m_sat = 1; end
                m_w = r; m_valid = 1; m_ltp = inf_ltp;
                inf_v = 0;
                if (pend_v != 0) begin
                    inf_v = 1; inf_ltp = pend_ltp; inf_dt = pend_dt; inf_due = now + 2;
                    pend_v = 0;
                end
            end else if (fsm_active == 0 && pend_v != 0) begin
                inf_v = 1; inf_ltp = pend_ltp; inf_dt = pend_dt; inf_due = now + 2;
                pend_v = 0;
            end
            if (ev != 0) begin
                if (fsm_active == 0 && had_pend == 0) begin
                    inf_v = 1; inf_ltp = ev_ltp; inf_dt = ev_dt; inf_due = now + 2;
                end else if (pend_v == 0) begin
                    pend_v = 1; pend_ltp = ev_ltp; pend_dt = ev_dt;
                end else begin
                    m_ovr = 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            if (update_valid) pulses++;
            chk("weight_out", int'(weight_out), m_w);
            chk("update_valid", int'(update_valid), m_valid);
            chk("update_ltp", int'(update_ltp), m_ltp);
            chk("update_sat", int'(update_sat), m_sat);
            chk("busy", int'(busy), (inf_v != 0 || pend_v != 0) ? 1 : 0);
            chk("overrun", int'(overrun), m_ovr);
        end
    end

    task automatic cycle(input logic p, input logic q, input logic l, input logic e,
                         input logic c, input logic [5:0] w);
        pre_spike = p; post_spike = q; learn_en = l; en = e; cfg_load = c; cfg_weight = w;
        @(posedge clk);
        model_step(int'(p), int'(q), int'(l), int'(e), int'(c), int'(w));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
    endtask

    task automatic load(input logic [5:0] w);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, w);
    endtask

    initial begin
        int p0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        en = 1'b1; learn_en = 1'b1;
        chk_on = 1'b1;
        chk("reset weight", int'(weight_out), 32);
        chk("reset busy", int'(busy), 0);
        chk("reset overrun", int'(overrun), 0);

        // LTP, dt = 3
        idle(20);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
        idle(2);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
        chk("ltp busy rise", int'(busy), 1);
        idle(1);
        chk("ltp weight before", int'(weight_out), 32);
        idle(1);
        chk("ltp weight", int'(weight_out), 34);
        chk("ltp valid", int'(update_valid), 1);
        chk("ltp polarity", int'(update_ltp), 1);
        chk("ltp sat", int'(update_sat), 0);
        idle(1);
        chk("ltp valid one cycle", int'(update_valid), 0);
        chk("ltp busy fall", int'(busy), 0);

        // LTD, dt = 10
        load(6'd32);
        idle(20);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
        idle(9);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
        idle(2);
        chk("ltd weight", int'(weight_out), 31);
        chk("ltd valid", int'(update_valid), 1);
        chk("ltd polarity", int'(update_ltp), 0);

        // No-update cases: out of window, coincident spikes, learning disabled
        load(6'd32);
        idle(20);
        p0 = pulses;
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
        idle(19);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
        idle(4);
        idle(20);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
        idle(4);
        idle(20);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
        idle(2);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
        idle(4);
        chk("no-update pulses", pulses - p0, 0);
        chk("no-update weight", int'(weight_out), 32);

        // Saturation at the top bound
        load(6'd62);
        chk("cfg weight", int'(weight_out), 62);
        idle(20);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
        idle(1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
        idle(2);
        chk("sat1 weight", int'(weight_out), 63);
        chk("sat1 flag", int'(update_sat), 1);
        idle(20);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
        idle(1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
        idle(2);
        chk("sat2 weight", int'(weight_out), 63);
        chk("sat2 flag", int'(update_sat), 1);

        // Burst of four posts: third queued event is dropped
        load(6'd32);
        idle(20);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
        idle(1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
        chk("burst upd1 weight", int'(weight_out), 34);
        chk("burst upd1 valid", int'(update_valid), 1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
        chk("burst overrun", int'(overrun), 1);
        idle(1);
        chk("burst upd2 weight", int'(weight_out), 36);
        idle(2);
        chk("burst upd3 weight", int'(weight_out), 38);
        chk("burst upd3 valid", int'(update_valid), 1);
        idle(1);
        chk("burst busy fall", int'(busy), 0);
        load(6'd20);
        chk("cfg clears overrun", int'(overrun), 0);
        chk("cfg weight 20", int'(weight_out), 20);

        // Asynchronous reset in the middle of an update
        load(6'd40);
        idle(20);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
        idle(1);
        chk_on = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async reset weight", int'(weight_out), 32);
        chk("async reset busy", int'(busy), 0);
        chk("async reset valid", int'(update_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_on = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 49) == 0), 6'($urandom_range(0, 63)));
        end
        idle(5);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
